// File: rtl/pixel_mem_if.sv
// Bundle of scan-read, write-request and block-memory signals around pixel_mem_arbiter.
// The slave view belongs to the arbiter and the master view to its surroundings.
interface pixel_mem_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 12
);
    logic              vga_valid;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] pix_out;
    logic              pix_valid;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_full;
    logic              wr_done;
    logic              overflow;
    logic              busy;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  vga_valid, vga_addr, wr_req, wr_addr, wr_data, mem_dout,
        output pix_out, pix_valid, wr_full, wr_done, overflow, busy,
        output mem_we, mem_addr, mem_din
    );

    modport master (
        output vga_valid, vga_addr, wr_req, wr_addr, wr_data, mem_dout,
        input  pix_out, pix_valid, wr_full, wr_done, overflow, busy,
        input  mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/pixel_mem_arbiter.sv
// Shares the single-port pixel memory between the VGA scan reads and buffered game writes.
// Scan reads own the memory during active video; queued writes drain one per blanking cycle.
module pixel_mem_arbiter #(
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    pixel_mem_if.slave    pm
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              pix_valid_q, pix_valid_d;
    logic [DATA_W-1:0] pix_out_q, pix_out_d;
    logic              wr_done_q, wr_done_d;
    logic              overflow_q, overflow_d;
    logic              wr_full_q, wr_full_d;
    logic              busy_q, busy_d;

    logic              empty_c;
    logic              full_c;
    logic              drain_c;
    logic              push_c;
    logic              pop_c;
    logic              pipe_v_c;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == FULL_CNT);

    // SCAN state is exactly "vga_valid was high last cycle", so it doubles as read-pipe stage 1.
    assign pipe_v_c = (state_q == SCAN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_out_q   <= '0;
            wr_done_q   <= 1'b0;
            overflow_q  <= 1'b0;
            wr_full_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pix_valid_q <= pix_valid_d;
            pix_out_q   <= pix_out_d;
            wr_done_q   <= wr_done_d;
            overflow_q  <= overflow_d;
            wr_full_q   <= wr_full_d;
            busy_q      <= busy_d;
        end
    end

    // Write-buffer storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            fifo_addr_q[wr_ptr_q] <= pm.wr_addr;
            fifo_data_q[wr_ptr_q] <= pm.wr_data;
        end
    end

    always_comb begin
        state_d     = IDLE;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pix_valid_d = pipe_v_c;
        pix_out_d   = '0;
        wr_done_d   = 1'b0;
        overflow_d  = overflow_q;
        drain_c     = 1'b0;
        push_c      = 1'b0;
        pop_c       = 1'b0;

        if (pm.vga_valid) begin
            state_d = SCAN;
        end else if (!empty_c) begin
            state_d = DRAIN;
        end

        drain_c = !pm.vga_valid && !empty_c;
        pop_c   = drain_c && !rst;
        push_c  = pm.wr_req && !full_c;

        if (pm.wr_req && full_c) begin
            overflow_d = 1'b1;
        end
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d   = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        wr_done_d = pop_c;

        if (pipe_v_c) begin
            pix_out_d = pm.mem_dout;
        end

        wr_full_d = (count_d == FULL_CNT);
        busy_d    = (count_d != '0);
    end

    // Memory port mux; a write never wins while the scan is active.
    always_comb begin
        pm.mem_we   = pop_c;
        pm.mem_addr = pm.vga_addr;
        pm.mem_din  = '0;
        if (drain_c) begin
            pm.mem_addr = fifo_addr_q[rd_ptr_q];
            pm.mem_din  = fifo_data_q[rd_ptr_q];
        end
    end

    assign pm.pix_out   = pix_out_q;
    assign pm.pix_valid = pix_valid_q;
    assign pm.wr_done   = wr_done_q;
    assign pm.overflow  = overflow_q;
    assign pm.wr_full   = wr_full_q;
    assign pm.busy      = busy_q;

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Self-checking bench for pixel_mem_arbiter: directed vector table, corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_pixel_mem_arbiter;
    localparam int unsigned AW    = 17;
    localparam int unsigned DW    = 12;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MEM_N = 1 << AW;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    pixel_mem_if #(.ADDR_W(AW), .DATA_W(DW)) pm ();

    pixel_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .pm  (pm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block-memory stand-in: read-first, one-cycle read latency.
    logic [DW-1:0] bram [MEM_N];
    always @(posedge clk) begin
        if (pm.mem_we) bram[pm.mem_addr] <= pm.mem_din;
        pm.mem_dout <= bram[pm.mem_addr];
    end

    // Reference model state
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;
    ent_t          mq[$];
    logic [DW-1:0] exp_mem [MEM_N];
    logic          m_pipe_v;
    logic [DW-1:0] m_pipe_d;
    logic [DW-1:0] e_pix;
    logic          e_pv;
    logic          e_done;
    logic          e_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pipe_v = 1'b0;
        m_pipe_d = '0;
        e_pix    = '0;
        e_pv     = 1'b0;
        e_done   = 1'b0;
        e_ovf    = 1'b0;
    endtask

    // One clock cycle: drive inputs, check the memory mux mid-cycle, then registered outputs.
    task automatic do_cycle(input logic r, input logic v, input logic [AW-1:0] va,
                            input logic rq, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            output logic obs_we, output logic [AW-1:0] obs_addr);
        logic          m_we;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_din;
        logic [DW-1:0] rd_now;
        int            sz0;
        rst          = r;
        pm.vga_valid = v;
        pm.vga_addr  = va;
        pm.wr_req    = rq;
        pm.wr_addr   = wa;
        pm.wr_data   = wd;
        @(negedge clk);
        sz0    = mq.size();
        m_we   = !r && !v && (sz0 != 0);
        m_addr = (!v && sz0 != 0) ? mq[0].a : va;
        m_din  = (!v && sz0 != 0) ? mq[0].d : '0;
        obs_we   = pm.mem_we;
        obs_addr = pm.mem_addr;
        chk("mem_we",   32'(pm.mem_we),   32'(m_we));
        chk("mem_addr", 32'(pm.mem_addr), 32'(m_addr));
        chk("mem_din",  32'(pm.mem_din),  32'(m_din));
        rd_now = exp_mem[m_addr];
        if (r) begin
            model_reset();
        end else begin
            e_pix    = m_pipe_v ? m_pipe_d : '0;
            e_pv     = m_pipe_v;
            m_pipe_v = v;
            m_pipe_d = rd_now;
            e_done   = m_we;
            if (m_we) begin
                exp_mem[mq[0].a] = mq[0].d;
                void'(mq.pop_front());
            end
            if (rq) begin
                if (sz0 < int'(DEPTH)) mq.push_back('{a: wa, d: wd});
                else                   e_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("pix_out",   32'(pm.pix_out),   32'(e_pix));
        chk("pix_valid", 32'(pm.pix_valid), 32'(e_pv));
        chk("wr_done",   32'(pm.wr_done),   32'(e_done));
        chk("wr_full",   32'(pm.wr_full),   32'(mq.size() == int'(DEPTH)));
        chk("busy",      32'(pm.busy),      32'(mq.size() != 0));
        chk("overflow",  32'(pm.overflow),  32'(e_ovf));
    endtask

    typedef struct {
        logic          r;
        logic          v;
        logic [AW-1:0] va;
        logic          rq;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic          e_done;
        logic          e_busy;
        logic          e_full;
        logic          e_ovf;
        logic          e_pv;
        logic [DW-1:0] e_pix;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic          we;
        logic [AW-1:0] ad;
        int            nwe;
        logic          v;
        int            run;

        for (int i = 0; i < int'(MEM_N); i++) begin
            bram[i]    = '0;
            exp_mem[i] = '0;
        end
        bram[17'h10]    = 12'hABC;
        exp_mem[17'h10] = 12'hABC;
        bram[17'h11]    = 12'h123;
        exp_mem[17'h11] = 12'h123;

        // Inputs, then: mem_we, mem_addr (mid-cycle); wr_done, busy, wr_full, overflow, pix_valid, pix_out (after edge)
        vecs[0]  = '{0, 1, 17'h10,  0, 17'h0,   12'h0,   0, 17'h10,  0, 0, 0, 0, 0, 12'h0};
        vecs[1]  = '{0, 1, 17'h11,  1, 17'h100, 12'hF00, 0, 17'h11,  0, 1, 0, 0, 1, 12'hABC};
        vecs[2]  = '{0, 1, 17'h12,  1, 17'h101, 12'h0F0, 0, 17'h12,  0, 1, 0, 0, 1, 12'h123};
        vecs[3]  = '{0, 1, 17'h12,  1, 17'h102, 12'h00F, 0, 17'h12,  0, 1, 0, 0, 1, 12'h0};
        vecs[4]  = '{0, 0, 17'h0,   0, 17'h0,   12'h0,   1, 17'h100, 1, 1, 0, 0, 1, 12'h0};
        vecs[5]  = '{0, 0, 17'h0,   0, 17'h0,   12'h0,   1, 17'h101, 1, 1, 0, 0, 0, 12'h0};
        vecs[6]  = '{0, 0, 17'h0,   0, 17'h0,   12'h0,   1, 17'h102, 1, 0, 0, 0, 0, 12'h0};
        vecs[7]  = '{0, 0, 17'h0,   0, 17'h0,   12'h0,   0, 17'h0,   0, 0, 0, 0, 0, 12'h0};
        vecs[8]  = '{0, 1, 17'h0,   1, 17'h200, 12'h111, 0, 17'h0,   0, 1, 0, 0, 0, 12'h0};
        vecs[9]  = '{0, 1, 17'h0,   1, 17'h201, 12'h222, 0, 17'h0,   0, 1, 0, 0, 1, 12'h0};
        vecs[10] = '{0, 1, 17'h0,   1, 17'h202, 12'h333, 0, 17'h0,   0, 1, 0, 0, 1, 12'h0};
        vecs[11] = '{0, 1, 17'h0,   1, 17'h203, 12'h444, 0, 17'h0,   0, 1, 1, 0, 1, 12'h0};
        vecs[12] = '{0, 1, 17'h0,   1, 17'h204, 12'h555, 0, 17'h0,   0, 1, 1, 1, 1, 12'h0};
        vecs[13] = '{0, 0, 17'h0,   0, 17'h0,   12'h0,   1, 17'h200, 1, 1, 0, 1, 1, 12'h0};
        vecs[14] = '{0, 0, 17'h0,   0, 17'h0,   12'h0,   1, 17'h201, 1, 1, 0, 1, 0, 12'h0};
        vecs[15] = '{0, 0, 17'h0,   0, 17'h0,   12'h0,   1, 17'h202, 1, 1, 0, 1, 0, 12'h0};
        vecs[16] = '{0, 0, 17'h0,   0, 17'h0,   12'h0,   1, 17'h203, 1, 0, 0, 1, 0, 12'h0};
        vecs[17] = '{0, 0, 17'h0,   0, 17'h0,   12'h0,   0, 17'h0,   0, 0, 0, 1, 0, 12'h0};

        rst          = 1'b1;
        pm.vga_valid = 1'b0;
        pm.vga_addr  = '0;
        pm.wr_req    = 1'b0;
        pm.wr_addr   = '0;
        pm.wr_data   = '0;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // Directed table
        do_cycle(1, 0, 0, 0, 0, 0, we, ad);
        for (int i = 0; i < 18; i++) begin
            do_cycle(vecs[i].r, vecs[i].v, vecs[i].va, vecs[i].rq, vecs[i].wa, vecs[i].wd, we, ad);
            chk("tbl_we",   32'(we),           32'(vecs[i].e_we));
            chk("tbl_addr", 32'(ad),           32'(vecs[i].e_addr));
            chk("tbl_done", 32'(pm.wr_done),   32'(vecs[i].e_done));
            chk("tbl_busy", 32'(pm.busy),      32'(vecs[i].e_busy));
            chk("tbl_full", 32'(pm.wr_full),   32'(vecs[i].e_full));
            chk("tbl_ovf",  32'(pm.overflow),  32'(vecs[i].e_ovf));
            chk("tbl_pv",   32'(pm.pix_valid), 32'(vecs[i].e_pv));
            chk("tbl_pix",  32'(pm.pix_out),   32'(vecs[i].e_pix));
        end

        // vga_valid rises between two queued writes
        do_cycle(1, 0, 0, 0, 0, 0, we, ad);
        do_cycle(0, 1, 17'h20, 1, 17'h300, 12'hAAA, we, ad);
        do_cycle(0, 1, 17'h21, 1, 17'h301, 12'hBBB, we, ad);
        do_cycle(0, 0, 17'h0, 0, 0, 0, we, ad);
        chk("hold_w1_we", 32'(we), 32'd1);
        chk("hold_w1_ad", 32'(ad), 32'h300);
        do_cycle(0, 1, 17'h22, 0, 0, 0, we, ad);
        chk("hold_we", 32'(we), 32'd0);
        chk("hold_busy", 32'(pm.busy), 32'd1);
        do_cycle(0, 0, 17'h0, 0, 0, 0, we, ad);
        chk("hold_w2_we", 32'(we), 32'd1);
        chk("hold_w2_ad", 32'(ad), 32'h301);
        do_cycle(0, 0, 17'h0, 0, 0, 0, we, ad);

        // Full FIFO: push during pop is dropped, next push lands while popping
        do_cycle(1, 0, 0, 0, 0, 0, we, ad);
        for (int i = 0; i < 4; i++)
            do_cycle(0, 1, 17'h0, 1, AW'(17'h400 + i), DW'(12'h100 * (i + 1)), we, ad);
        do_cycle(0, 0, 17'h0, 1, 17'h404, 12'h999, we, ad);
        nwe = int'(we);
        chk("fullpop_ovf",  32'(pm.overflow), 32'd1);
        chk("fullpop_full", 32'(pm.wr_full),  32'd0);
        do_cycle(0, 0, 17'h0, 1, 17'h405, 12'h888, we, ad);
        nwe += int'(we);
        chk("pushpop_full", 32'(pm.wr_full), 32'd0);
        chk("pushpop_busy", 32'(pm.busy),    32'd1);
        for (int i = 0; i < 6; i++) begin
            do_cycle(0, 0, 17'h0, 0, 0, 0, we, ad);
            nwe += int'(we);
        end
        chk("fullpop_writes", 32'(nwe), 32'd5);
        chk("fullpop_idle",   32'(pm.busy), 32'd0);

        // Reset mid-drain with three entries still queued
        do_cycle(1, 0, 0, 0, 0, 0, we, ad);
        for (int i = 0; i < 5; i++)
            do_cycle(0, 1, 17'h10, 1, AW'(17'h500 + i), DW'(12'h0A0 + i), we, ad);
        do_cycle(0, 0, 17'h0, 0, 0, 0, we, ad);
        do_cycle(1, 0, 17'h0, 0, 0, 0, we, ad);
        chk("rst_we",   32'(we),           32'd0);
        chk("rst_busy", 32'(pm.busy),      32'd0);
        chk("rst_full", 32'(pm.wr_full),   32'd0);
        chk("rst_ovf",  32'(pm.overflow),  32'd0);
        chk("rst_pix",  32'(pm.pix_out),   32'd0);
        nwe = 0;
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 0, 17'h0, 0, 0, 0, we, ad);
            nwe += int'(we) + int'(pm.wr_done);
        end
        chk("rst_no_activity", 32'(nwe), 32'd0);

        // Randomized traffic against the reference model
        v   = 1'b0;
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                v   = ~v;
                run = $urandom_range(1, 12);
            end
            run--;
            do_cycle(($urandom_range(0, 299) == 0), v,
                     AW'(17'h500 + $urandom_range(0, 7)),
                     ($urandom_range(0, 9) < 4),
                     AW'(17'h500 + $urandom_range(0, 7)),
                     DW'($urandom_range(0, 4095)), we, ad);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
